// File: rtl/uart_tx_pkg.sv
// Shared constants for the Hack I/O UART transmitter: FSM encodings,
// status-word bit positions and default sizing.
package uart_tx_pkg;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

    localparam int unsigned STATUS_FULL          = 15;
    localparam int unsigned STATUS_ACTIVE        = 14;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;
    localparam int unsigned BYTE_W               = 8;
    localparam int unsigned WORD_W               = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word fall-through synchronous FIFO; rd_data is valid whenever !empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes through load/in,
// a FIFO queues them and the frame FSM shifts them out LSB first on tx.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] in,
    output logic              tx,
    output logic [WORD_W-1:0] out
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [WORD_W-1:0] out_q, out_d;

    logic              push_c;
    logic              pop_c;
    logic              bit_end_c;
    logic [CW-1:0]     count_d;
    logic [BYTE_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              unused_hi;

    assign unused_hi = ^in[WORD_W-1:BYTE_W];
    assign push_c    = load && !fifo_full;
    assign bit_end_c = (timer_q == TW'(CLKS_PER_BIT - 1));

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_c),
        .wr_data (in[BYTE_W-1:0]),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Frame sequencing; STOP end chains straight into the next START when data is queued.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;

        if (state_q != UART_IDLE) begin
            timer_d = bit_end_c ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rd_data;
                    tx_d    = 1'b0;
                    timer_d = '0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (bit_end_c) begin
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    state_d = UART_DATA;
                end
            end
            UART_DATA: begin
                if (bit_end_c) begin
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = UART_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[BYTE_W-1:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            UART_STOP: begin
                if (bit_end_c) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_rd_data;
                        tx_d    = 1'b0;
                        state_d = UART_START;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                timer_d = '0;
                state_d = UART_IDLE;
            end
        endcase
    end

    // Status reflects the post-edge FIFO occupancy and FSM state.
    always_comb begin
        count_d = fifo_count + CW'(push_c) - CW'(pop_c);
        out_d   = '0;
        out_d[STATUS_FULL]   = (count_d == CW'(FIFO_DEPTH));
        out_d[STATUS_ACTIVE] = (state_d != UART_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UART_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            out_q   <= out_d;
        end
    end

    assign tx  = tx_q;
    assign out = out_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: cycle-accurate frame model plus an
// independent serial decoder compared against the accepted byte stream.
module tb_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] in;
    logic        tx;
    logic [15:0] out;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [7:0] cur = 8'h00;
    int         remain = 0;

    // Decoder state
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    int         decoded = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .in    (in),
        .tx    (tx),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the abstract transmitter: queue of bytes + frame countdown.
    task automatic model_step(input logic rst_v, input logic ld_v, input logic [7:0] d_v);
        int  c;
        bit  push;
        bit  pop;
        if (rst_v) begin
            mq.delete();
            sent_q.delete();
            remain = 0;
        end else begin
            c    = mq.size();
            push = ld_v && (c < DEPTH);
            pop  = (remain <= 1) && (c > 0);
            if (pop) begin
                cur    = mq.pop_front();
                remain = FRAME;
            end else if (remain > 0) begin
                remain--;
            end
            if (push) begin
                mq.push_back(d_v);
                sent_q.push_back(d_v);
            end
        end
    endtask

    function automatic logic exp_tx();
        int p;
        int b;
        if (remain == 0) return 1'b1;
        p = FRAME - remain;
        b = p / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_out(input logic rst_v);
        logic [15:0] v;
        v = 16'h0000;
        if (!rst_v) begin
            v[15] = (mq.size() == DEPTH);
            v[14] = (remain > 0) || (mq.size() > 0);
        end
        return v;
    endfunction

    // Mid-bit sampling decoder, independent of the model's frame counter.
    task automatic decode(input logic rst_v);
        if (rst_v) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                rx_byte = 8'h00;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB) == (CPB / 2) && rx_cnt < 9 * CPB) begin
                rx_byte[rx_cnt / CPB - 1] = tx;
            end
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                check_val("rx_stop", {15'b0, tx}, 16'h0001);
                if (sent_q.size() == 0) begin
                    check_val("rx_extra_byte", {8'h00, rx_byte}, 16'hFFFF);
                end else begin
                    check_val("rx_byte", {8'h00, rx_byte}, {8'h00, sent_q.pop_front()});
                end
                decoded++;
                rx_busy = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic rst_v, input logic ld_v, input logic [15:0] d_v);
        reset = rst_v;
        load  = ld_v;
        in    = d_v;
        @(posedge clk);
        model_step(rst_v, ld_v, d_v[7:0]);
        #1;
        check_val("tx", {15'b0, tx}, {15'b0, exp_tx()});
        check_val("status", out, exp_out(rst_v));
        decode(rst_v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        int acc;
        int cyc;
        int pre;
        logic ld;
        logic [15:0] d;

        reset = 1'b1;
        load  = 1'b0;
        in    = 16'h0000;

        // Reset state
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000);
        check_val("reset_out", out, 16'h0000);
        check_val("reset_tx", {15'b0, tx}, 16'h0001);
        idle(5);

        // Single frame; upper byte of the write word is ignored
        cycle(1'b0, 1'b1, 16'hFF55);
        idle(45);
        check_val("decoded_single", 16'(decoded), 16'd1);

        // Reset held 3 cycles mid-frame, then line stays quiet
        cycle(1'b0, 1'b1, 16'h00C3);
        idle(15);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000);
        check_val("abort_out", out, 16'h0000);
        check_val("abort_tx", {15'b0, tx}, 16'h0001);
        idle(50);

        // Burst until full; the write that arrives while full is dropped
        cycle(1'b0, 1'b1, 16'h0011);
        cycle(1'b0, 1'b1, 16'h0022);
        cycle(1'b0, 1'b1, 16'h0033);
        cycle(1'b0, 1'b1, 16'h0044);
        cycle(1'b0, 1'b1, 16'h0055);
        check_val("burst_full", {15'b0, out[15]}, 16'h0001);
        cycle(1'b0, 1'b1, 16'h0066);
        idle(5 * FRAME + 10);
        check_val("burst_drained", 16'(sent_q.size()), 16'd0);

        // Load on the same edge IDLE pops the previous byte
        cycle(1'b0, 1'b1, 16'h00AA);
        cycle(1'b0, 1'b1, 16'h00BB);
        idle(2 * FRAME + 5);

        // Reset during data bit 3, then a clean A5 frame
        cycle(1'b0, 1'b1, 16'h005A);
        idle(1 + CPB * 4 + 1);
        cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 16'h00A5);
        pre = decoded;
        idle(FRAME + 5);
        check_val("a5_decoded", 16'(decoded - pre), 16'd1);

        // Random stream with load gated by the full flag
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 60000) begin
            ld  = !out[15] && ($urandom_range(0, 3) != 0);
            d   = 16'($urandom);
            pre = mq.size();
            cycle(1'b0, ld, d);
            if (ld && pre < DEPTH) acc++;
            cyc++;
        end
        check_val("random_accepted", 16'(acc), 16'd1000);
        cyc = 0;
        while ((remain > 0 || mq.size() > 0 || rx_busy) && cyc < 2000) begin
            cycle(1'b0, 1'b0, 16'h0000);
            cyc++;
        end
        idle(3);
        check_val("stream_drained", 16'(sent_q.size()), 16'd0);
        check_val("final_status", out, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
